// File: rtl/bypass_reg_file_if.sv
// Port bundle for bypass_reg_file: read ports, writeback ports, issue-side
// alloc/flush and the pending-register count.
interface bypass_reg_file_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int AW    = $clog2(NREGS),
   parameter int CW    = $clog2(NREGS+1)
);
   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][XLEN-1:0] rd_data;
   logic [NRD-1:0]           rd_busy;
   logic [NWR-1:0]           wr_en;
   logic [NWR-1:0][AW-1:0]   wr_addr;
   logic [NWR-1:0][XLEN-1:0] wr_data;
   logic                     alloc_en;
   logic [AW-1:0]            alloc_addr;
   logic                     flush;
   logic [CW-1:0]            busy_count;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      input  rd_data, rd_busy, busy_count
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr, flush,
      output rd_data, rd_busy, busy_count
   );
endinterface

// File: rtl/bypass_reg_file.sv
// Multi-port register file with same-cycle write bypass and a pending-write
// scoreboard; x0 is hardwired to zero and never pending.
module bypass_rd_port #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NWR   = 2,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic                     reset,
   input  logic [AW-1:0]            rd_addr,
   input  logic [NREGS-1:0][XLEN-1:0] regs,
   input  logic [NREGS-1:0]         busy,
   input  logic [NWR-1:0]           wr_en,
   input  logic [NWR-1:0][AW-1:0]   wr_addr,
   input  logic [NWR-1:0][XLEN-1:0] wr_data,
   output logic [XLEN-1:0]          rd_data,
   output logic                     rd_busy
);
   // Ascending scan so the youngest (highest-index) matching writer wins.
   // Bypass is gated by reset so outputs are zero while reset is held.
   always_comb begin
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
      for (int i = 0; i < NWR; i++) begin
         if (!reset && wr_en[i] && wr_addr[i] == rd_addr && rd_addr != '0) begin
            rd_data = wr_data[i];
            rd_busy = 1'b0;
         end
      end
   end
endmodule

module bypass_reg_file #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 2
) (
   input logic clock,
   input logic reset,
   bypass_reg_file_if.slave rf
);
   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(NREGS+1);

   // Entry 0 of both arrays is never written, so it stays zero.
   logic [NREGS-1:0][XLEN-1:0] regs, regs_nx;
   logic [NREGS-1:0]           busy, busy_nx;
   logic [CW-1:0]              cnt, cnt_nx;
   logic [NRD-1:0][XLEN-1:0]   rd_data_w;
   logic [NRD-1:0]             rd_busy_w;

   // Writes clear busy first; alloc then re-sets it, since the alloc belongs
   // to a younger instruction. Flush overrides alloc but not data writes.
   always_comb begin
      regs_nx = regs;
      busy_nx = busy;
      for (int i = 0; i < NWR; i++) begin
         if (rf.wr_en[i] && rf.wr_addr[i] != '0) begin
            regs_nx[rf.wr_addr[i]] = rf.wr_data[i];
            busy_nx[rf.wr_addr[i]] = 1'b0;
         end
      end
      if (rf.flush)
         busy_nx = '0;
      else if (rf.alloc_en && rf.alloc_addr != '0)
         busy_nx[rf.alloc_addr] = 1'b1;
      cnt_nx = '0;
      for (int r = 1; r < NREGS; r++)
         cnt_nx = cnt_nx + CW'(busy_nx[r]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs <= '0;
         busy <= '0;
         cnt  <= '0;
      end else begin
         regs <= regs_nx;
         busy <= busy_nx;
         cnt  <= cnt_nx;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      bypass_rd_port #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .AW(AW)) u_port (
         .reset   (reset),
         .rd_addr (rf.rd_addr[p]),
         .regs    (regs),
         .busy    (busy),
         .wr_en   (rf.wr_en),
         .wr_addr (rf.wr_addr),
         .wr_data (rf.wr_data),
         .rd_data (rd_data_w[p]),
         .rd_busy (rd_busy_w[p])
      );
   end

   assign rf.rd_data    = rd_data_w;
   assign rf.rd_busy    = rd_busy_w;
   assign rf.busy_count = cnt;
endmodule

// File: tb/tb_bypass_reg_file.sv
// Directed plus random checks of bypass_reg_file against an array-based model.
module tb_bypass_reg_file;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = $clog2(NREGS);
   localparam int CW    = $clog2(NREGS+1);

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   bypass_reg_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) rf ();

   bypass_reg_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clock (clock),
      .reset (reset),
      .rf    (rf.slave)
   );

   int n_chk = 0;
   int n_bad = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_busy [NREGS];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int r = 0; r < NREGS; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int r = 0; r < NREGS; r++) c += m_busy[r];
      return c;
   endfunction

   // Expected read: youngest same-cycle writer to a nonzero address, else array.
   task automatic check_reads();
      for (int p = 0; p < NRD; p++) begin
         logic [AW-1:0]   a  = rf.rd_addr[p];
         logic [XLEN-1:0] ed = m_regs[a];
         logic            eb = m_busy[a];
         for (int i = 0; i < NWR; i++)
            if (rf.wr_en[i] && rf.wr_addr[i] == a && a != 0) begin
               ed = rf.wr_data[i];
               eb = 1'b0;
            end
         chk("rd_data", 64'(rf.rd_data[p]), 64'(ed));
         chk("rd_busy", 64'(rf.rd_busy[p]), 64'(eb));
      end
   endtask

   task automatic m_edge();
      for (int i = 0; i < NWR; i++)
         if (rf.wr_en[i] && rf.wr_addr[i] != 0) begin
            m_regs[rf.wr_addr[i]] = rf.wr_data[i];
            m_busy[rf.wr_addr[i]] = 1'b0;
         end
      if (rf.flush)
         for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
      else if (rf.alloc_en && rf.alloc_addr != 0)
         m_busy[rf.alloc_addr] = 1'b1;
   endtask

   // Inputs are set just after a rising edge; reads checked mid-cycle.
   task automatic cyc();
      @(negedge clock);
      check_reads();
      @(posedge clock);
      m_edge();
      #1;
      chk("busy_count", 64'(rf.busy_count), 64'(m_count()));
   endtask

   task automatic idle();
      rf.wr_en = '0; rf.alloc_en = 1'b0; rf.flush = 1'b0;
   endtask

   task automatic rd2(input int a0, input int a1);
      rf.rd_addr[0] = AW'(a0); rf.rd_addr[1] = AW'(a1);
   endtask

   task automatic rand_cycle();
      rf.wr_en      = NWR'($urandom);
      rf.alloc_en   = $urandom_range(0, 1) == 1;
      rf.alloc_addr = AW'($urandom_range(0, NREGS-1));
      rf.flush      = $urandom_range(0, 15) == 0;
      for (int i = 0; i < NWR; i++) begin
         rf.wr_addr[i] = AW'($urandom_range(0, 7) < 2 ? $urandom_range(0, 3) : $urandom_range(0, NREGS-1));
         rf.wr_data[i] = XLEN'($urandom);
      end
      for (int p = 0; p < NRD; p++)
         rf.rd_addr[p] = $urandom_range(0, 1) == 1 ? rf.wr_addr[$urandom_range(0, NWR-1)]
                                                    : AW'($urandom_range(0, NREGS-1));
      cyc();
   endtask

   initial begin
      idle();
      rf.wr_addr = '0; rf.wr_data = '0; rf.alloc_addr = '0; rd2(0, 0);
      m_reset();
      // Reset held: every address reads zero, not busy.
      #2;
      for (int a = 0; a < NREGS; a++) begin
         rd2(a, NREGS-1-a);
         #1;
         check_reads();
      end
      chk("reset_count", 64'(rf.busy_count), 64'(0));
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;

      // Write x5 with same-cycle read, then read from array.
      rf.wr_en = 2'b01; rf.wr_addr[0] = 5; rf.wr_data[0] = 32'hDEADBEEF; rd2(5, 5);
      cyc();
      idle(); cyc();
      chk("x5_hold", 64'(rf.rd_data[0]), 64'h0DEADBEEF);
      // x0 writes ignored.
      rf.wr_en = 2'b01; rf.wr_addr[0] = 0; rf.wr_data[0] = 32'h1234; rd2(0, 5);
      cyc();
      idle(); cyc();
      chk("x0_zero", 64'(rf.rd_data[0]), 64'h0);

      // Two ports write x7: port 1 wins.
      rf.wr_en = 2'b11; rf.wr_addr[0] = 7; rf.wr_data[0] = 32'h11;
      rf.wr_addr[1] = 7; rf.wr_data[1] = 32'h22; rd2(7, 7);
      cyc();
      idle(); cyc();
      chk("x7_port1", 64'(rf.rd_data[1]), 64'h22);

      // Alloc x3; write+alloc x3 keeps busy; lone write clears.
      rd2(3, 0);
      rf.alloc_en = 1'b1; rf.alloc_addr = 3; cyc();
      idle(); cyc();
      chk("x3_busy", 64'(rf.rd_busy[0]), 64'h1);
      chk("x3_count", 64'(rf.busy_count), 64'h1);
      rf.wr_en = 2'b01; rf.wr_addr[0] = 3; rf.wr_data[0] = 32'hA5A5;
      rf.alloc_en = 1'b1; rf.alloc_addr = 3; cyc();
      idle(); cyc();
      chk("x3_realloc", 64'(rf.rd_busy[0]), 64'h1);
      rf.wr_en = 2'b10; rf.wr_addr[1] = 3; rf.wr_data[1] = 32'h5A5A; cyc();
      idle(); cyc();
      chk("x3_clear", 64'(rf.busy_count), 64'h0);

      // Alloc x1..x3, then flush with alloc x4.
      for (int a = 1; a <= 3; a++) begin
         rf.alloc_en = 1'b1; rf.alloc_addr = AW'(a); rd2(a, 4); cyc();
      end
      chk("pre_flush_count", 64'(rf.busy_count), 64'h3);
      rf.alloc_en = 1'b1; rf.alloc_addr = 4; rf.flush = 1'b1; cyc();
      idle();
      for (int a = 1; a <= 7; a++) begin
         rd2(a, 8 - a); cyc();
      end
      chk("flush_count", 64'(rf.busy_count), 64'h0);
      chk("flush_x7", 64'(rf.rd_data[0]), 64'h22);

      for (int n = 0; n < 400; n++) rand_cycle();

      // Asynchronous reset between edges: outputs clear at once.
      idle(); rd2(7, 5);
      #2;
      reset = 1'b1;
      #1;
      m_reset();
      check_reads();
      chk("async_count", 64'(rf.busy_count), 64'h0);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      for (int n = 0; n < 200; n++) rand_cycle();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/bypass_reg_file.md
# bypass_reg_file

Parametrised multi-port integer register file with same-cycle write-to-read bypass and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the pipelined core. The decode stage reads operands and hazard status from it. Writeback ports update values and retire pending entries, and issue marks destinations as pending.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, architectural register count; legal values 16 (RV32E) or 32; AW = $clog2(NREGS).
- NRD, 2, number of read ports (1–4).
- NWR, 2, number of write ports (1–2); a higher index means a younger writeback.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD×AW  read address per port.
- rd_data  out  NRD×XLEN  read data per port, combinational.
- rd_busy  out  NRD  pending-write flag of the addressed register, combinational.
- wr_en  in  NWR  write enable per port.
- wr_addr  in  NWR×AW  write address per port.
- wr_data  in  NWR×XLEN  write data per port.
- alloc_en  in  1  mark alloc_addr as having a pending write.
- alloc_addr  in  AW  destination register being issued.
- flush  in  1  clear all pending flags; register data is kept.
- busy_count  out  $clog2(NREGS+1)  registered count of pending registers.

## Operation
- State consists of a register array regs[1..NREGS-1] and a busy bit vector busy[1..NREGS-1].
- Register x0 is hardwired:
  - Reads of x0 return 0 with rd_busy 0.
  - Writes to x0 and allocs of x0 are ignored.
- Reset (asynchronous assert) forces:
  - all regs to 0;
  - all busy bits to 0;
  - busy_count to 0.
  - Consequently rd_data is 0 and rd_busy is 0 for every port while reset is held.
- Write rules:
  - On each rising edge, each port i with wr_en[i]=1 and wr_addr[i]≠0 writes wr_data[i].
  - If several ports target the same address, the highest index wins.
  - A write clears busy[wr_addr].
- Read and bypass rules, per read port:
  - If an enabled write port targets the same nonzero address this cycle, rd_data is that port's wr_data (highest index wins) and rd_busy is 0.
  - Otherwise rd_data = regs[rd_addr] and rd_busy = busy[rd_addr].
- Alloc rules:
  - alloc_en with alloc_addr≠0 sets busy[alloc_addr] on the next edge.
  - If alloc and a write hit the same address in one cycle, the data is written and busy ends at 1, because the alloc belongs to a younger instruction.
- Flush rules:
  - flush clears every busy bit on the next edge.
  - flush has priority over a same-cycle alloc, so the alloc is dropped.
  - Same-cycle writes still update data.
- busy_count is the popcount of the busy vector after the edge's update. It is registered and never exceeds NREGS-1.

## Timing
- Read latency is 0 cycles; read paths are purely combinational from addresses, array, and write ports.
- A written value appears via bypass in the same cycle and from the array from the next cycle on.
- busy set by alloc is visible on rd_busy and busy_count one cycle after alloc_en.
- busy clear by write is visible on rd_busy in the same cycle via bypass and in busy_count the next cycle.
- Reset mid-operation:
  - Outputs return to their reset values immediately, without waiting for a clock edge.
  - Deassertion must be synchronous to clock externally.
  - The first edge after deassertion may write or alloc normally.
- There are no stall or handshake signals; all inputs are sampled every cycle.

## Test plan
- Reset, then read x0–x31 on all ports -> all rd_data 0, rd_busy 0, busy_count 0.
- Write x5=0xDEADBEEF on port 0 while reading x5 in the same cycle -> rd_data 0xDEADBEEF same cycle and the next cycle; write x0=0x1234 -> x0 still reads 0.
- Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle -> the same-cycle read and later reads return 0x22.
- alloc x3 -> next cycle rd_busy=1, busy_count=1; a write to x3 with a simultaneous alloc of x3 -> data updated, busy stays 1; a later write alone -> busy 0, count 0.
- Alloc x1, x2, x3 over three cycles, then flush together with alloc x4 -> all busy 0 and busy_count 0; register data is unchanged.
- Assert reset asynchronously between edges after filling registers -> rd_data goes to 0 immediately; with NREGS=16, an AW=4 build passes the same suite.
